// File: rtl/gray_seq_monitor.sv
// rtl/gray_seq_monitor.sv - Gray-code sequence monitor: converts, checks step order, locks and counts errors
module gray_seq_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             locked,
    output logic             seq_error,
    output logic             wrap,
    output logic [7:0]       err_count
);
    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [7:0]       good_cnt_q, good_cnt_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             serr_q, serr_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       err_q, err_d;

    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] diff;
    logic             one_bit, is_repeat, is_good, is_bad;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        bin_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_c[i] = ^(gray_in >> i);
        end
    end

    // bin_q always holds the binary of prev_gray_q, so it doubles as the reference.
    assign diff      = gray_in ^ prev_gray_q;
    assign is_repeat = (diff == '0);
    assign one_bit   = !is_repeat && ((diff & (diff - WIDTH'(1))) == '0);
    assign is_good   = one_bit && (bin_c == bin_q + WIDTH'(1));
    assign is_bad    = !is_good && !is_repeat;

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        prev_gray_d = prev_gray_q;
        bin_d       = bin_q;
        valid_d     = 1'b0;
        serr_d      = 1'b0;
        wrap_d      = 1'b0;
        err_d       = err_q;
        if (enable) begin
            prev_gray_d = gray_in;
            bin_d       = bin_c;
            valid_d     = 1'b1;
            case (state_q)
                IDLE: begin
                    good_cnt_d = 8'd0;
                    state_d    = SYNC;
                end
                SYNC: begin
                    if (is_good) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if (good_cnt_q + 8'd1 >= 8'(LOCK_COUNT)) state_d = LOCKED;
                    end else if (is_bad) begin
                        good_cnt_d = 8'd0;
                    end
                end
                LOCKED: begin
                    if (is_good) begin
                        wrap_d = (bin_q == '1) && (bin_c == '0);
                    end else if (is_bad) begin
                        serr_d     = 1'b1;
                        good_cnt_d = 8'd0;
                        state_d    = SYNC;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            good_cnt_q  <= 8'd0;
            prev_gray_q <= '0;
            bin_q       <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            serr_q      <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            prev_gray_q <= prev_gray_d;
            bin_q       <= bin_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            serr_q      <= serr_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = valid_q;
    assign locked    = locked_q;
    assign seq_error = serr_q;
    assign wrap      = wrap_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_gray_seq_monitor.sv
// tb/tb_gray_seq_monitor.sv - scoreboard bench for gray_seq_monitor
module tb_gray_seq_monitor;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] gray_in = 4'd0;
    logic [3:0] bin_out;
    logic       bin_valid, locked, seq_error, wrap;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int bin;
        int lck;
        int err;
        int serr;
        int wrp;
    } exp_t;
    exp_t sb[$];

    gray_seq_monitor #(.WIDTH(4), .LOCK_COUNT(4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .gray_in(gray_in),
        .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
        .seq_error(seq_error), .wrap(wrap), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every bin_valid pulse consumes one expected response.
    always @(negedge clock) begin
        if (bin_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got bin_valid=1 expected none pending");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (int'(bin_out) != e.bin || int'(locked) != e.lck || int'(err_count) != e.err ||
                    int'(seq_error) != e.serr || int'(wrap) != e.wrp) begin
                    errors++;
                    $display("FAIL sample: got bin=%0d lck=%0d err=%0d serr=%0d wrap=%0d expected bin=%0d lck=%0d err=%0d serr=%0d wrap=%0d",
                             bin_out, locked, err_count, seq_error, wrap, e.bin, e.lck, e.err, e.serr, e.wrp);
                end
            end
        end else if (!reset) begin
            if (seq_error || wrap) begin
                checks++;
                errors++;
                $display("FAIL pulse_without_valid: got serr=%0d wrap=%0d expected 0 0", seq_error, wrap);
            end
        end
    end

    task automatic send(input logic [3:0] g, input int eb, input int el, input int ee, input int es, input int ew);
        exp_t e;
        @(negedge clock);
        reset   = 1'b0;
        enable  = 1'b1;
        gray_in = g;
        e.bin = eb; e.lck = el; e.err = ee; e.serr = es; e.wrp = ew;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic [3:0] g);
        @(negedge clock);
        reset   = 1'b1;
        enable  = 1'b1;
        gray_in = g;
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b0;
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_bin_valid", int'(bin_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_seq_error", int'(seq_error), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_err_count", int'(err_count), 0);
    endtask

    function automatic logic [3:0] b2g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    initial begin
        int b;
        int sat;
        do_reset(4'b0000);

        // lock from zero
        send(4'b0000, 0, 0, 0, 0, 0);
        send(4'b0001, 1, 0, 0, 0, 0);
        send(4'b0011, 2, 0, 0, 0, 0);
        send(4'b0010, 3, 0, 0, 0, 0);
        send(4'b0110, 4, 1, 0, 0, 0);
        send(4'b0110, 4, 1, 0, 0, 0);

        // lock ending at code 0011 (15->0 in SYNC is not a wrap), then a multi-bit jump
        do_reset(4'b0000);
        send(4'b1001, 14, 0, 0, 0, 0);
        send(4'b1000, 15, 0, 0, 0, 0);
        send(4'b0000, 0, 0, 0, 0, 0);
        send(4'b0001, 1, 0, 0, 0, 0);
        send(4'b0011, 2, 1, 0, 0, 0);
        send(4'b0101, 6, 0, 1, 1, 0);
        send(4'b0100, 7, 0, 1, 0, 0);
        send(4'b1100, 8, 0, 1, 0, 0);
        send(4'b1101, 9, 0, 1, 0, 0);
        send(4'b1111, 10, 1, 1, 0, 0);
        send(4'b1110, 11, 1, 1, 0, 0);
        send(4'b1010, 12, 1, 1, 0, 0);
        send(4'b1011, 13, 1, 1, 0, 0);
        send(4'b1001, 14, 1, 1, 0, 0);
        send(4'b1000, 15, 1, 1, 0, 0);
        send(4'b0000, 0, 1, 1, 0, 1);
        send(4'b0001, 1, 1, 1, 0, 0);

        // single-bit decrement from code 0011
        do_reset(4'b0000);
        send(4'b1001, 14, 0, 0, 0, 0);
        send(4'b1000, 15, 0, 0, 0, 0);
        send(4'b0000, 0, 0, 0, 0, 0);
        send(4'b0001, 1, 0, 0, 0, 0);
        send(4'b0011, 2, 1, 0, 0, 0);
        send(4'b0001, 1, 0, 1, 1, 0);
        send(4'b0011, 2, 0, 1, 0, 0);
        send(4'b0010, 3, 0, 1, 0, 0);
        send(4'b0110, 4, 0, 1, 0, 0);
        send(4'b0111, 5, 1, 1, 0, 0);

        // hold with enable low
        @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            gray_in = 4'(i * 7);
            @(negedge clock);
            chk("hold_bin_out", int'(bin_out), 5);
            chk("hold_locked", int'(locked), 1);
            chk("hold_err_count", int'(err_count), 1);
            chk("hold_bin_valid", int'(bin_valid), 0);
        end

        // build err_count up to 3 then reset while locked
        send(4'b0100, 7, 0, 2, 1, 0);
        send(4'b1100, 8, 0, 2, 0, 0);
        send(4'b1101, 9, 0, 2, 0, 0);
        send(4'b1111, 10, 0, 2, 0, 0);
        send(4'b1110, 11, 1, 2, 0, 0);
        send(4'b0000, 0, 0, 3, 1, 0);
        send(4'b0001, 1, 0, 3, 0, 0);
        send(4'b0011, 2, 0, 3, 0, 0);
        send(4'b0010, 3, 0, 3, 0, 0);
        send(4'b0110, 4, 1, 3, 0, 0);
        do_reset(4'b0101);
        send(4'b0111, 5, 0, 0, 0, 0);

        // saturation: re-lock then a single-bit decrement, 300 times
        do_reset(4'b0000);
        send(4'b0000, 0, 0, 0, 0, 0);
        b = 0;
        for (int i = 0; i < 300; i++) begin
            sat = (i > 255) ? 255 : i;
            for (int k = 1; k <= 4; k++) begin
                send(b2g(b + k), (b + k) % 16, (k == 4) ? 1 : 0, sat, 0, 0);
            end
            sat = (i + 1 > 255) ? 255 : i + 1;
            send(b2g(b + 3), (b + 3) % 16, 0, sat, 1, 0);
            b = (b + 3) % 16;
        end
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        chk("final_err_count", int'(err_count), 255);

        for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_seq_monitor.md
GRAY_SEQ_MONITOR -- requirements
Module: gray_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, code width in bits.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, number of consecutive good steps required to lock (legal range 1..255).
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  sample qualifier; gray_in is accepted on a rising clock edge only when enable=1.
REQ-006 SHALL have port gray_in  input  WIDTH  Gray code from the upstream Gray-code counter.
REQ-007 SHALL have port bin_out  output  WIDTH  registered binary equivalent of the last accepted gray_in.
REQ-008 SHALL have port bin_valid  output  1  one-cycle pulse marking each new bin_out.
REQ-009 SHALL have port locked  output  1  level; high while in state LOCKED.
REQ-010 SHALL have port seq_error  output  1  one-cycle pulse on a sequence violation detected in LOCKED.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on a good step from all-ones to zero (binary) while in LOCKED.
REQ-012 SHALL have port err_count  output  8  saturating count of seq_error pulses since reset.

Function
REQ-013 SHALL convert Gray to binary combinationally: b[W-1]=g[W-1]; b[i]=b[i+1] XOR g[i].
REQ-014 SHALL register all outputs; each output reflects a sample accepted at edge N from edge N onward (visible in cycle N+1).
REQ-015 SHALL pulse bin_valid for exactly one cycle after every accepted sample, in every state.
REQ-016 SHALL classify each accepted sample, relative to the previously accepted one, as follows:
- good: exactly one bit differs AND bin == prev_bin+1 mod 2^WIDTH;
- repeat: identical code;
- bad: anything else, including a single-bit change that decrements.
REQ-017 SHALL implement states IDLE, SYNC and LOCKED with a good-step counter good_cnt.
REQ-018 SHALL, in IDLE on an accepted sample: store the sample, clear good_cnt, and go to SYNC (no classification).
REQ-019 SHALL, in SYNC:
- good: increment good_cnt, and go to LOCKED when good_cnt reaches LOCK_COUNT;
- bad: clear good_cnt, stay in SYNC, do not pulse seq_error;
- repeat: no change.
REQ-020 SHALL, in LOCKED:
- good or repeat: stay in LOCKED;
- bad: pulse seq_error, increment err_count, clear good_cnt, go to SYNC.
REQ-021 SHALL hold err_count at 255 once it reaches 255.
REQ-022 SHALL, with enable=0, hold state, good_cnt, bin_out and err_count, and SHALL hold bin_valid, seq_error and wrap at 0.
REQ-023 SHALL store every accepted sample as the new reference for the next classification, whatever its class.
REQ-024 SHALL assert locked in the same cycle that the state is LOCKED.
REQ-025 SHALL, for a bad step leaving LOCKED, produce seq_error=1 and locked=0 in the same cycle.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set state to IDLE, clear good_cnt and the stored sample, and drive all outputs to 0.
REQ-027 SHALL give reset priority over enable; a sample presented in the reset cycle is discarded.
REQ-028 SHALL, when reset occurs mid-operation in LOCKED, restart the module from IDLE with err_count=0.

Verification
REQ-029 SHALL pass this lock scenario (LOCK_COUNT=4): enable=1; gray_in 0000,0001,0011,0010,0110 on successive edges -> bin_out 0,1,2,3,4; locked rises in the cycle after the 5th sample; seq_error stays 0.
REQ-030 SHALL pass this wrap scenario: locked, feed gray 1000 (bin 15) then 0000 -> wrap=1 for one cycle; bin_out=0; locked stays 1.
REQ-031 SHALL pass these error scenarios, run separately from a locked state with last code 0011 (bin 2):
- feed 0101 -> seq_error pulse, err_count=1, locked=0;
- feed 0001 (single-bit decrement) -> seq_error pulse, err_count=1, locked=0.
REQ-032 SHALL pass this hold scenario: enable=0 for 10 cycles while locked -> bin_out, locked and err_count unchanged; bin_valid=0 throughout.
REQ-033 SHALL pass this saturation scenario: 300 forced bad steps, each preceded by re-lock -> err_count=255.
REQ-034 SHALL pass this reset scenario: reset=1 for one edge while locked with err_count=3 -> next cycle all outputs 0; the next accepted sample produces no seq_error.
